// File: rtl/sargantana_icache_pkg.sv
// -----------------------------------------------------------------------------
// sargantana_icache_pkg
// Shared types and sizing constants for the icache iFill responder.
//   ifill_state_t      : responder FSM states
//   IFILL_BEATS        : memory beats per cache line
//   IFILL_OFFSET_BITS  : byte-offset bits cleared to line-align an address
// -----------------------------------------------------------------------------
package sargantana_icache_pkg;

    localparam int IFILL_PADDR_SIZE  = 40;
    localparam int IFILL_LINE_BITS   = 128;
    localparam int IFILL_MEM_DATA_W  = 64;
    localparam int IFILL_WAY_BITS    = 2;
    localparam int IFILL_BEATS       = IFILL_LINE_BITS / IFILL_MEM_DATA_W;
    localparam int IFILL_OFFSET_BITS = $clog2(IFILL_LINE_BITS / 8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        RESP
    } ifill_state_t;

endpackage

// File: rtl/sargantana_icache_ifill_responder_if.sv
// -----------------------------------------------------------------------------
// sargantana_icache_ifill_responder_if
// Bundles the iFill request/response channel, the beat-based memory read port
// and the external invalidate input seen by the iFill responder.
//   slave  : responder view (drives ifill_resp_*, mem_req_valid_o/addr_o)
//   master : environment view (icache + memory + invalidate source)
// -----------------------------------------------------------------------------
interface sargantana_icache_ifill_responder_if
    import sargantana_icache_pkg::*;
#(
    parameter int PADDR_SIZE = IFILL_PADDR_SIZE,
    parameter int LINE_BITS  = IFILL_LINE_BITS,
    parameter int MEM_DATA_W = IFILL_MEM_DATA_W,
    parameter int WAY_BITS   = IFILL_WAY_BITS
);

    logic                  ifill_req_valid_i;
    logic [WAY_BITS-1:0]   ifill_req_way_i;
    logic [PADDR_SIZE-1:0] ifill_req_paddr_i;
    logic                  ifill_resp_valid_o;
    logic                  ifill_resp_ack_o;
    logic [LINE_BITS-1:0]  ifill_resp_data_o;
    logic                  ifill_resp_inv_valid_o;
    logic [PADDR_SIZE-1:0] ifill_resp_inv_paddr_o;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [PADDR_SIZE-1:0] mem_req_addr_o;
    logic                  mem_rvalid_i;
    logic [MEM_DATA_W-1:0] mem_rdata_i;
    logic                  mem_rerror_i;
    logic                  inv_valid_i;
    logic [PADDR_SIZE-1:0] inv_paddr_i;

    modport slave (
        input  ifill_req_valid_i, ifill_req_way_i, ifill_req_paddr_i,
        output ifill_resp_valid_o, ifill_resp_ack_o, ifill_resp_data_o,
        output ifill_resp_inv_valid_o, ifill_resp_inv_paddr_o,
        output mem_req_valid_o, mem_req_addr_o,
        input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i, mem_rerror_i,
        input  inv_valid_i, inv_paddr_i
    );

    modport master (
        output ifill_req_valid_i, ifill_req_way_i, ifill_req_paddr_i,
        input  ifill_resp_valid_o, ifill_resp_ack_o, ifill_resp_data_o,
        input  ifill_resp_inv_valid_o, ifill_resp_inv_paddr_o,
        input  mem_req_valid_o, mem_req_addr_o,
        output mem_req_ready_i, mem_rvalid_i, mem_rdata_i, mem_rerror_i,
        output inv_valid_i, inv_paddr_i
    );

endinterface

// File: rtl/sargantana_ifill_line_buffer.sv
// -----------------------------------------------------------------------------
// sargantana_ifill_line_buffer
// Assembles in-order memory beats into one cache line.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   clr_i         : restart the beat counter (line contents are kept)
//   wr_en_i       : write wr_data_i into the slot of the current beat
//   wr_data_i     : beat data
//   line_o        : assembled line register
//   last_beat_o   : the next write completes the line
// -----------------------------------------------------------------------------
module sargantana_ifill_line_buffer
    import sargantana_icache_pkg::*;
#(
    parameter int LINE_BITS  = IFILL_LINE_BITS,
    parameter int MEM_DATA_W = IFILL_MEM_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [MEM_DATA_W-1:0] wr_data_i,
    output logic [LINE_BITS-1:0]  line_o,
    output logic                  last_beat_o
);

    localparam int BEATS = LINE_BITS / MEM_DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]     cnt_q;
    logic [LINE_BITS-1:0] line_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (wr_en_i) begin
            line_q[int'(cnt_q) * MEM_DATA_W +: MEM_DATA_W] <= wr_data_i;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign line_o      = line_q;
    assign last_beat_o = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/sargantana_icache_ifill_responder.sv
// -----------------------------------------------------------------------------
// sargantana_icache_ifill_responder
// Serves icache line fills: one line-aligned read on the memory port, beats
// assembled into a line, then a one-cycle ack (with valid unless the fill saw
// a beat error or a matching invalidation). External invalidations are
// forwarded to the icache one cycle later, independent of the fill FSM.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset (aborts any fill in flight)
//   bus    : iFill request/response, memory read port and invalidate input
// -----------------------------------------------------------------------------
module sargantana_icache_ifill_responder
    import sargantana_icache_pkg::*;
#(
    parameter int PADDR_SIZE = IFILL_PADDR_SIZE,
    parameter int LINE_BITS  = IFILL_LINE_BITS,
    parameter int MEM_DATA_W = IFILL_MEM_DATA_W,
    parameter int WAY_BITS   = IFILL_WAY_BITS
) (
    input logic                            clk_i,
    input logic                            rstn_i,
    sargantana_icache_ifill_responder_if.slave bus
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam logic [PADDR_SIZE-1:0] OFFSET_MASK =
        PADDR_SIZE'((64'd1 << OFFSET_BITS) - 64'd1);

    function automatic logic [PADDR_SIZE-1:0] line_addr(input logic [PADDR_SIZE-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

    ifill_state_t          state_q, state_d;
    logic [PADDR_SIZE-1:0] addr_q;
    logic [WAY_BITS-1:0]   way_q;
    logic                  err_q, kill_q;
    logic                  inv_valid_q;
    logic [PADDR_SIZE-1:0] inv_paddr_q;

    logic                  capture, beat_wr, busy, inv_hit, last_beat;
    logic [PADDR_SIZE-1:0] match_addr;
    logic [LINE_BITS-1:0]  line;
    logic                  req_valid, resp_ack, resp_valid;

    // The way is recorded for the transaction but nothing downstream needs it.
    logic unused_way;
    assign unused_way = ^way_q;

    assign capture = (state_q == IDLE) && bus.ifill_req_valid_i;
    assign beat_wr = (state_q == DATA) && bus.mem_rvalid_i;
    assign busy    = (state_q == REQ) || (state_q == DATA);

    // An invalidate arriving with the request is matched against that request.
    assign match_addr = capture ? line_addr(bus.ifill_req_paddr_i) : addr_q;
    assign inv_hit    = bus.inv_valid_i && (capture || busy) &&
                        (line_addr(bus.inv_paddr_i) == match_addr);

    sargantana_ifill_line_buffer #(
        .LINE_BITS  (LINE_BITS),
        .MEM_DATA_W (MEM_DATA_W)
    ) u_line_buffer (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clr_i       (capture),
        .wr_en_i     (beat_wr),
        .wr_data_i   (bus.mem_rdata_i),
        .line_o      (line),
        .last_beat_o (last_beat)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        resp_ack   = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: if (bus.ifill_req_valid_i) state_d = REQ;
            REQ: begin
                req_valid = 1'b1;
                if (bus.mem_req_ready_i) state_d = DATA;
            end
            DATA: if (beat_wr && last_beat) state_d = RESP;
            RESP: begin
                resp_ack   = 1'b1;
                resp_valid = !(err_q || kill_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q <= '0;
            way_q  <= '0;
            err_q  <= 1'b0;
            kill_q <= 1'b0;
        end else if (capture) begin
            addr_q <= line_addr(bus.ifill_req_paddr_i);
            way_q  <= bus.ifill_req_way_i;
            err_q  <= 1'b0;
            kill_q <= inv_hit;
        end else begin
            if (beat_wr && bus.mem_rerror_i) err_q <= 1'b1;
            if (inv_hit) kill_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inv_valid_q <= 1'b0;
            inv_paddr_q <= '0;
        end else begin
            inv_valid_q <= bus.inv_valid_i;
            if (bus.inv_valid_i) inv_paddr_q <= bus.inv_paddr_i;
        end
    end

    assign bus.mem_req_valid_o        = req_valid;
    assign bus.mem_req_addr_o         = addr_q;
    assign bus.ifill_resp_ack_o       = resp_ack;
    assign bus.ifill_resp_valid_o     = resp_valid;
    assign bus.ifill_resp_data_o      = line;
    assign bus.ifill_resp_inv_valid_o = inv_valid_q;
    assign bus.ifill_resp_inv_paddr_o = inv_paddr_q;

    // Beats may only arrive while the line is being assembled.
    a_rvalid_only_in_data: assert property (
        @(posedge clk_i) disable iff (!rstn_i) bus.mem_rvalid_i |-> (state_q == DATA)
    );

endmodule
